// File: rtl/wsg_nch_seq_if.sv
// Bus bundle for wsg_nch_seq: CPU register-write port, shared wave ROM port and mixed PCM output.
interface wsg_nch_seq_if #(
  parameter int NCH = 8,
  parameter int FW  = 20,
  parameter int WW  = 3,
  parameter int OW  = 10
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             CPU_WE;
  logic [CHW-1:0]   CPU_CH;
  logic [1:0]       CPU_SEL;
  logic [FW-1:0]    CPU_DATA;
  logic [WW+4:0]    WROM_ADDR;
  logic [3:0]       WROM_DATA;
  logic [OW-1:0]    PCM_OUT;
  logic             PCM_VALID;
  logic             BUSY;

  modport slave (
    input  CPU_WE, CPU_CH, CPU_SEL, CPU_DATA, WROM_DATA,
    output WROM_ADDR, PCM_OUT, PCM_VALID, BUSY
  );

  modport master (
    output CPU_WE, CPU_CH, CPU_SEL, CPU_DATA, WROM_DATA,
    input  WROM_ADDR, PCM_OUT, PCM_VALID, BUSY
  );
endinterface

// File: rtl/wsg_nch_seq.sv
// N-channel wavetable sound generator: channels share one wave ROM port, scanned once per sample tick,
// products summed into a wide mix and saturated onto the PCM output.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for the sample tick from the divider
//   S_SCAN  | one channel per cycle: advance phase, issue ROM address, mix previous product
//   S_DRAIN | mix the final channel's product, load saturated PCM word
//   S_OUT   | PCM_VALID high for one cycle, then back to idle
module wsg_nch_seq #(
  parameter int NCH = 8,
  parameter int FW  = 20,
  parameter int WW  = 3,
  parameter int VW  = 4,
  parameter int OW  = 10,
  parameter int DIV = 500
) (
  input  logic          CLK48M,
  input  logic          RESET_N,
  wsg_nch_seq_if.slave  bus
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MW  = VW + 4 + $clog2(NCH) + 1;
  localparam int PW  = VW + 4;
  localparam int DW  = $clog2(DIV);
  localparam int AW  = WW + 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  if (DIV < NCH + 4 || NCH > 16 || NCH < 1 || FW < 5) begin : g_param_check
    $error("wsg_nch_seq: illegal parameters (need 1<=NCH<=16, DIV>=NCH+4, FW>=5)");
  end

  logic [WW-1:0]  wave_q [NCH];
  logic [WW-1:0]  wave_d [NCH];
  logic [VW-1:0]  vol_q  [NCH];
  logic [VW-1:0]  vol_d  [NCH];
  logic [FW-1:0]  freq_q [NCH];
  logic [FW-1:0]  freq_d [NCH];
  logic [FW-1:0]  acc_q  [NCH];
  logic [FW-1:0]  acc_d  [NCH];

  logic [DW-1:0]  cnt_q, cnt_d;
  logic [1:0]     state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [MW-1:0]  mix_q, mix_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [OW-1:0]  pcm_q, pcm_d;
  logic           valid_q, valid_d;
  logic           p_vld_q, p_vld_d;
  logic [VW-1:0]  p_vol_q, p_vol_d;
  logic           p_gate_q, p_gate_d;

  logic           tick;
  logic           ch_ok;
  logic [FW-1:0]  acc_new;
  logic [PW-1:0]  prod;
  logic [MW-1:0]  mix_acc;
  logic [OW-1:0]  sat_val;

  assign tick = (cnt_q == DW'(DIV - 1));

  if (NCH == (1 << CHW)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (bus.CPU_CH < CHW'(NCH));
  end

  // Volume and frequency-gate are captured at issue time, so stage 2 sees the pre-write values.
  assign prod    = p_gate_q ? (PW'(p_vol_q) * PW'(bus.WROM_DATA)) : '0;
  assign mix_acc = mix_q + MW'(prod);

  if (MW > OW) begin : g_sat
    assign sat_val = (|mix_acc[MW-1:OW]) ? '1 : mix_acc[OW-1:0];
  end else begin : g_nosat
    assign sat_val = OW'(mix_acc);
  end

  always_comb begin
    wave_d   = wave_q;
    vol_d    = vol_q;
    freq_d   = freq_q;
    acc_d    = acc_q;
    cnt_d    = tick ? '0 : cnt_q + DW'(1);
    state_d  = state_q;
    ch_d     = ch_q;
    mix_d    = mix_q;
    addr_d   = addr_q;
    pcm_d    = pcm_q;
    valid_d  = 1'b0;
    p_vld_d  = 1'b0;
    p_vol_d  = p_vol_q;
    p_gate_d = p_gate_q;
    acc_new  = '0;

    if (bus.CPU_WE && ch_ok) begin
      case (bus.CPU_SEL)
        2'b00:   wave_d[bus.CPU_CH] = bus.CPU_DATA[WW-1:0];
        2'b01:   vol_d[bus.CPU_CH]  = bus.CPU_DATA[VW-1:0];
        2'b10:   freq_d[bus.CPU_CH] = bus.CPU_DATA;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_SCAN;
          ch_d    = '0;
          mix_d   = '0;
        end
      end
      S_SCAN: begin
        acc_new     = acc_q[ch_q] + freq_q[ch_q];
        acc_d[ch_q] = acc_new;
        addr_d      = {wave_q[ch_q], acc_new[FW-1:FW-5]};
        p_vld_d     = 1'b1;
        p_vol_d     = vol_q[ch_q];
        p_gate_d    = |freq_q[ch_q];
        if (p_vld_q) mix_d = mix_acc;
        if (ch_q == CHW'(NCH - 1)) state_d = S_DRAIN;
        else                       ch_d    = ch_q + CHW'(1);
      end
      S_DRAIN: begin
        mix_d   = mix_acc;
        pcm_d   = sat_val;
        valid_d = 1'b1;
        state_d = S_OUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK48M) begin
    if (!RESET_N) begin
      for (int i = 0; i < NCH; i++) begin
        wave_q[i] <= '0;
        vol_q[i]  <= '0;
        freq_q[i] <= '0;
        acc_q[i]  <= '0;
      end
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      ch_q     <= '0;
      mix_q    <= '0;
      addr_q   <= '0;
      pcm_q    <= '0;
      valid_q  <= 1'b0;
      p_vld_q  <= 1'b0;
      p_vol_q  <= '0;
      p_gate_q <= 1'b0;
    end else begin
      wave_q   <= wave_d;
      vol_q    <= vol_d;
      freq_q   <= freq_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      ch_q     <= ch_d;
      mix_q    <= mix_d;
      addr_q   <= addr_d;
      pcm_q    <= pcm_d;
      valid_q  <= valid_d;
      p_vld_q  <= p_vld_d;
      p_vol_q  <= p_vol_d;
      p_gate_q <= p_gate_d;
    end
  end

  assign bus.WROM_ADDR = addr_q;
  assign bus.PCM_OUT   = pcm_q;
  assign bus.PCM_VALID = valid_q;
  assign bus.BUSY      = (state_q != S_IDLE);

endmodule
